time_set_ctrl: RTL and testbench

Button-driven time/date editor that writes a new time into the calendar clock counter. It is the writer side of the clock's time fields. It seeds its edit registers from the clock's current outputs and walks the user through year, month, day, hour and minute fields. On commit it issues a one-cycle load strobe with the edited values, and seconds are forced to 0. Field widths and ranges match the clock counter: 30-day months, 24-hour day.

---
 rtl/time_set_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Button-driven editor for the calendar clock's time fields. Entering edit
// mode seeds the edit registers from the running clock. The user then steps
// through year, month, day, hour and minute. Committing issues a one-cycle
// load strobe carrying the edited values, with seconds forced to zero.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   btn_mode_i                   enter edit / advance to next field (debounced level)
//   btn_inc_i, btn_dec_i         step current field up / down (debounced level)
//   cur_*_i                      clock's current year/month/day/hour/minute
//   set_*_o                      edited values (set_second_o is always 0)
//   load_o                       one-cycle strobe, set_*_o valid in that cycle
//   editing_o                    high while editing or committing
//   field_o                      0=none 1=year 2=month 3=day 4=hour 5=minute
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | not editing, set_* hold last edited/committed values
// SET_YEAR  | stepping year   (YEAR_MIN..YEAR_MAX)
// SET_MONTH | stepping month  (1..12)
// SET_DAY   | stepping day    (1..30)
// SET_HOUR  | stepping hour   (0..23)
// SET_MIN   | stepping minute (0..59)
// COMMIT    | one cycle, raises load on the following cycle

module time_set_ctrl #(
  parameter int YEAR_MIN       = 2000,
  parameter int YEAR_MAX       = 2099,
  parameter int HOLD_CYCLES    = 500,
  parameter int REPEAT_CYCLES  = 100,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btn_mode_i,
  input  logic        btn_inc_i,
  input  logic        btn_dec_i,
  input  logic [11:0] cur_year_i,
  input  logic [3:0]  cur_month_i,
  input  logic [4:0]  cur_day_i,
  input  logic [5:0]  cur_hour_i,
  input  logic [5:0]  cur_minute_i,
  output logic [11:0] set_year_o,
  output logic [3:0]  set_month_o,
  output logic [4:0]  set_day_o,
  output logic [5:0]  set_hour_o,
  output logic [5:0]  set_minute_o,
  output logic [5:0]  set_second_o,
  output logic        load_o,
  output logic        editing_o,
  output logic [2:0]  field_o
);

  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RW-1:0] HOLD_LD = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_LD  = RW'(REPEAT_CYCLES);
  localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_CYCLES);
  localparam logic [11:0]   Y_LO    = 12'(YEAR_MIN);
  localparam logic [11:0]   Y_HI    = 12'(YEAR_MAX);

  typedef enum logic [2:0] {
    IDLE, SET_YEAR, SET_MONTH, SET_DAY, SET_HOUR, SET_MIN, COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic          mode_hist_q, inc_hist_q, dec_hist_q;
  logic [RW-1:0] inc_rep_q, dec_rep_q;
  logic [TW-1:0] to_q, to_d;
  logic [11:0]   year_q, year_d;
  logic [3:0]    month_q, month_d;
  logic [4:0]    day_q, day_d;
  logic [5:0]    hour_q, hour_d;
  logic [5:0]    minute_q, minute_d;
  logic          load_q, editing_q;
  logic [2:0]    field_q;

  logic mode_edge, inc_edge, dec_edge, any_edge;
  logic inc_tick, dec_tick, inc_step, dec_step, up, dn;
  logic in_set, timeout;

  function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lo,
                                        input logic [11:0] hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Wrapping step; the >=/<= compares keep an out-of-range value from
  // running away even though entry clamping should prevent one.
  function automatic logic [11:0] step(input logic [11:0] v, input logic [11:0] lo,
                                       input logic [11:0] hi, input logic inc,
                                       input logic dec);
    if (inc) return (v >= hi) ? lo : v + 12'd1;
    if (dec) return (v <= lo) ? hi : v - 12'd1;
    return v;
  endfunction

  function automatic logic [2:0] field_of(input state_t s);
    case (s)
      SET_YEAR:  return 3'd1;
      SET_MONTH: return 3'd2;
      SET_DAY:   return 3'd3;
      SET_HOUR:  return 3'd4;
      SET_MIN:   return 3'd5;
      default:   return 3'd0;
    endcase
  endfunction

  assign mode_edge = btn_mode_i & ~mode_hist_q;
  assign inc_edge  = btn_inc_i  & ~inc_hist_q;
  assign dec_edge  = btn_dec_i  & ~dec_hist_q;
  assign any_edge  = mode_edge | inc_edge | dec_edge;

  // Repeat counters only advance while the other step button is released.
  assign inc_tick = btn_inc_i & ~btn_dec_i & (inc_rep_q == RW'(1));
  assign dec_tick = btn_dec_i & ~btn_inc_i & (dec_rep_q == RW'(1));
  assign inc_step = inc_edge | inc_tick;
  assign dec_step = dec_edge | dec_tick;
  assign up       = inc_step & ~dec_step;
  assign dn       = dec_step & ~inc_step;

  assign in_set  = (state_q == SET_YEAR) || (state_q == SET_MONTH) || (state_q == SET_DAY) ||
                   (state_q == SET_HOUR) || (state_q == SET_MIN);
  assign timeout = (to_q == TW'(1)) & ~any_edge;

  always_comb begin
    state_d  = state_q;
    to_d     = to_q;
    year_d   = year_q;
    month_d  = month_q;
    day_d    = day_q;
    hour_d   = hour_q;
    minute_d = minute_q;

    if (in_set) begin
      if (any_edge)         to_d = TO_LD;
      else if (to_q != '0)  to_d = to_q - TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (mode_edge) begin
          state_d  = SET_YEAR;
          to_d     = TO_LD;
          year_d   = clamp(cur_year_i, Y_LO, Y_HI);
          month_d  = cur_month_i;
          day_d    = cur_day_i;
          hour_d   = cur_hour_i;
          minute_d = cur_minute_i;
        end
      end
      SET_YEAR: begin
        if (mode_edge) begin
          state_d = SET_MONTH;
          month_d = 4'(clamp({8'd0, month_q}, 12'd1, 12'd12));
        end else if (timeout) state_d = IDLE;
        else year_d = step(year_q, Y_LO, Y_HI, up, dn);
      end
      SET_MONTH: begin
        if (mode_edge) begin
          state_d = SET_DAY;
          day_d   = 5'(clamp({7'd0, day_q}, 12'd1, 12'd30));
        end else if (timeout) state_d = IDLE;
        else month_d = 4'(step({8'd0, month_q}, 12'd1, 12'd12, up, dn));
      end
      SET_DAY: begin
        if (mode_edge) begin
          state_d = SET_HOUR;
          hour_d  = 6'(clamp({6'd0, hour_q}, 12'd0, 12'd23));
        end else if (timeout) state_d = IDLE;
        else day_d = 5'(step({7'd0, day_q}, 12'd1, 12'd30, up, dn));
      end
      SET_HOUR: begin
        if (mode_edge) begin
          state_d  = SET_MIN;
          minute_d = 6'(clamp({6'd0, minute_q}, 12'd0, 12'd59));
        end else if (timeout) state_d = IDLE;
        else hour_d = 6'(step({6'd0, hour_q}, 12'd0, 12'd23, up, dn));
      end
      SET_MIN: begin
        if (mode_edge)    state_d = COMMIT;
        else if (timeout) state_d = IDLE;
        else minute_d = 6'(step({6'd0, minute_q}, 12'd0, 12'd59, up, dn));
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode_hist_q <= 1'b0;
      inc_hist_q  <= 1'b0;
      dec_hist_q  <= 1'b0;
      to_q        <= '0;
      year_q      <= Y_LO;
      month_q     <= 4'd1;
      day_q       <= 5'd1;
      hour_q      <= 6'd0;
      minute_q    <= 6'd0;
      load_q      <= 1'b0;
      editing_q   <= 1'b0;
      field_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      mode_hist_q <= btn_mode_i;
      inc_hist_q  <= btn_inc_i;
      dec_hist_q  <= btn_dec_i;
      to_q        <= to_d;
      year_q      <= year_d;
      month_q     <= month_d;
      day_q       <= day_d;
      hour_q      <= hour_d;
      minute_q    <= minute_d;
      // load trails COMMIT by a cycle; editing is held through that cycle
      // so it drops together with load.
      load_q      <= (state_q == COMMIT);
      editing_q   <= (state_d != IDLE) || (state_q == COMMIT);
      field_q     <= field_of(state_d);
    end
  end

  // Down-counters: reload HOLD on the press, tick at terminal count 1,
  // then reload REPEAT. Frozen while the opposite button is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inc_rep_q <= '0;
      dec_rep_q <= '0;
    end else begin
      if (!btn_inc_i)                inc_rep_q <= '0;
      else if (inc_edge)             inc_rep_q <= HOLD_LD;
      else if (!btn_dec_i) begin
        if (inc_rep_q == RW'(1))     inc_rep_q <= REP_LD;
        else if (inc_rep_q != '0)    inc_rep_q <= inc_rep_q - RW'(1);
      end

      if (!btn_dec_i)                dec_rep_q <= '0;
      else if (dec_edge)             dec_rep_q <= HOLD_LD;
      else if (!btn_inc_i) begin
        if (dec_rep_q == RW'(1))     dec_rep_q <= REP_LD;
        else if (dec_rep_q != '0)    dec_rep_q <= dec_rep_q - RW'(1);
      end
    end
  end

  assign set_year_o   = year_q;
  assign set_month_o  = month_q;
  assign set_day_o    = day_q;
  assign set_hour_o   = hour_q;
  assign set_minute_o = minute_q;
  assign set_second_o = 6'd0;
  assign load_o       = load_q;
  assign editing_o    = editing_q;
  assign field_o      = field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int TOUT = 100;

  logic        clk, rst;
  logic        btn_mode, btn_inc, btn_dec;
  logic [11:0] cur_year;
  logic [3:0]  cur_month;
  logic [4:0]  cur_day;
  logic [5:0]  cur_hour, cur_minute;
  logic [11:0] set_year;
  logic [3:0]  set_month;
  logic [4:0]  set_day;
  logic [5:0]  set_hour, set_minute, set_second;
  logic        load, editing;
  logic [2:0]  field;

  time_set_ctrl #(
    .YEAR_MIN(2000), .YEAR_MAX(2099),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .btn_mode_i(btn_mode), .btn_inc_i(btn_inc), .btn_dec_i(btn_dec),
    .cur_year_i(cur_year), .cur_month_i(cur_month), .cur_day_i(cur_day),
    .cur_hour_i(cur_hour), .cur_minute_i(cur_minute),
    .set_year_o(set_year), .set_month_o(set_month), .set_day_o(set_day),
    .set_hour_o(set_hour), .set_minute_o(set_minute), .set_second_o(set_second),
    .load_o(load), .editing_o(editing), .field_o(field)
  );

  typedef struct packed {
    logic [11:0] y;
    logic [3:0]  mo;
    logic [4:0]  d;
    logic [5:0]  h;
    logic [5:0]  mi;
    logic [5:0]  s;
  } tr_t;

  tr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  logic prev_load = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every load pulse is matched against the next queued expectation.
  always @(negedge clk) begin
    if (load) begin
      tr_t got, want;
      got = '{y: set_year, mo: set_month, d: set_day, h: set_hour, mi: set_minute, s: set_second};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_load actual=%0d/%0d/%0d %0d:%0d:%0d required=no_load",
                 got.y, got.mo, got.d, got.h, got.mi, got.s);
      end else begin
        want = exp_q.pop_front();
        if (got != want) begin
          failures++;
          $display("FAIL load_tx actual=%0d/%0d/%0d %0d:%0d:%0d required=%0d/%0d/%0d %0d:%0d:%0d",
                   got.y, got.mo, got.d, got.h, got.mi, got.s,
                   want.y, want.mo, want.d, want.h, want.mi, want.s);
        end
      end
      if (prev_load) begin
        failures++;
        $display("FAIL load_back_to_back actual=1 required=0");
      end
    end
    prev_load = load;
  end

  task automatic press(input logic m, input logic i, input logic d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi);
    cur_year = 12'(y); cur_month = 4'(mo); cur_day = 5'(d);
    cur_hour = 6'(h);  cur_minute = 6'(mi);
  endtask

  initial begin
    rst = 1'b1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    set_cur(2021, 1, 1, 0, 0);
    repeat (3) @(negedge clk);

    chk("rst_year", set_year, 2000);
    chk("rst_month", set_month, 1);
    chk("rst_day", set_day, 1);
    chk("rst_hour_min", {set_hour, set_minute}, 0);
    chk("rst_second", set_second, 0);
    chk("rst_load_edit_field", {load, editing, field}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic pass-through commit
    press(1, 0, 0);
    chk("enter_field", field, 1);
    chk("enter_year", set_year, 2021);
    chk("enter_editing", editing, 1);
    exp_q.push_back('{y: 12'd2021, mo: 4'd1, d: 5'd1, h: 6'd0, mi: 6'd0, s: 6'd0});
    for (int k = 2; k <= 5; k++) begin
      press(1, 0, 0);
      chk("advance_field", field, k);
    end
    press(1, 0, 0);
    chk("commit_field", field, 0);
    chk("commit_editing_with_load", editing, 1);
    repeat (2) @(negedge clk);
    chk("post_commit_editing", editing, 0);
    chk("post_commit_year", set_year, 2021);

    // Wraps, auto-repeat, cancel, mode precedence
    set_cur(2050, 6, 30, 0, 0);
    press(1, 0, 0);
    chk("y2050", set_year, 2050);
    press(1, 0, 0);
    chk("m6", set_month, 6);
    press(1, 0, 0);
    chk("day30", set_day, 30);
    press(0, 1, 0);
    chk("day_wrap_up", set_day, 1);
    press(1, 0, 0);
    chk("hour0", set_hour, 0);
    press(0, 0, 1);
    chk("hour_wrap_down", set_hour, 23);
    press(1, 0, 0);
    chk("min_field", field, 5);
    chk("min0", set_minute, 0);
    btn_inc = 1'b1;
    repeat (HOLD + 2 * REP) @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
    chk("hold_repeat", set_minute, 3);
    repeat (40) @(negedge clk);
    chk("after_release", set_minute, 3);
    press(0, 1, 1);
    chk("inc_dec_cancel", set_minute, 3);
    chk("cancel_field", field, 5);
    exp_q.push_back('{y: 12'd2050, mo: 4'd6, d: 5'd1, h: 6'd23, mi: 6'd3, s: 6'd0});
    press(1, 1, 0);
    chk("mode_inc_field", field, 0);
    chk("mode_inc_value", set_minute, 3);
    repeat (3) @(negedge clk);

    // Clamping on entry, year/month/minute wraps, then timeout abort
    set_cur(2150, 0, 31, 25, 61);
    press(1, 0, 0);
    chk("clamp_year_hi", set_year, 2099);
    press(0, 1, 0);
    chk("year_wrap_up", set_year, 2000);
    press(1, 0, 0);
    chk("clamp_month_lo", set_month, 1);
    press(0, 0, 1);
    chk("month_wrap_down", set_month, 12);
    press(1, 0, 0);
    chk("clamp_day_hi", set_day, 30);
    press(1, 0, 0);
    chk("clamp_hour_hi", set_hour, 23);
    press(1, 0, 0);
    chk("clamp_min_hi", set_minute, 59);
    press(0, 1, 0);
    chk("min_wrap_up", set_minute, 0);
    repeat (TOUT - 5) @(negedge clk);
    chk("before_timeout_editing", editing, 1);
    repeat (15) @(negedge clk);
    chk("timeout_editing", editing, 0);
    chk("timeout_field", field, 0);
    chk("timeout_keeps_year", set_year, 2000);
    chk("timeout_keeps_month", set_month, 12);

    // Reset in the middle of an edit
    set_cur(2021, 3, 15, 10, 20);
    press(1, 0, 0);
    press(1, 0, 0);
    chk("pre_rst_field", field, 2);
    rst = 1'b1;
    #1;
    chk("midrst_field", field, 0);
    chk("midrst_editing_load", {editing, load}, 0);
    chk("midrst_year", set_year, 2000);
    chk("midrst_month", set_month, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press(1, 0, 0);
    chk("reenter_field", field, 1);
    chk("reenter_year", set_year, 2021);

    repeat (5) @(negedge clk);
    chk("all_loads_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
